// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg -- shared types and default timing for the DVP transmitter.
//   state_t   : FSM state encoding used by dvp_tx
//   DEF_*     : default frame geometry / blanking lengths (pclk cycles)
//   CNT_W     : width of the pixel, line and blanking counters
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    LINE,
    HBLANK,
    VFP
  } state_t;

  localparam int DEF_WIDTH      = 1280;
  localparam int DEF_HEIGHT     = 720;
  localparam int DEF_VSYNC_CYC  = 8;
  localparam int DEF_VBP_CYC    = 16;
  localparam int DEF_HBLANK_CYC = 16;
  localparam int DEF_VFP_CYC    = 16;

  localparam int CNT_W = 16;

endpackage

// File: rtl/dvp_tx_pattern.sv
// dvp_tx_pattern -- internal test-pattern source for dvp_tx.
// Only compiled when DVP_TX_TEST_PATTERN_EN is defined.
// Ports:
//   i_hcnt  [7:0]  : current pixel index within the line
//   i_vcnt  [7:0]  : current line index
//   o_pixel [15:0] : pattern pixel {line, pixel}
`ifdef DVP_TX_TEST_PATTERN_EN
module dvp_tx_pattern (
  input  logic [7:0]  i_hcnt,
  input  logic [7:0]  i_vcnt,
  output logic [15:0] o_pixel
);

  assign o_pixel = {i_vcnt, i_hcnt};

endmodule
`endif

// File: rtl/dvp_tx.sv
// dvp_tx -- DVP (8-bit parallel camera bus) frame transmitter.
// Takes a 16-bit pixel stream and sends each pixel as two bytes (low, high)
// framed by vsync / href, with programmable blanking.
// Optional feature: define DVP_TX_TEST_PATTERN_EN to enable the internal
// {line, pixel} test pattern selected by test_mode.
// Ports:
//   pclk, rst               : clock, asynchronous active-high reset
//   enable                  : frame start request (sampled in IDLE only)
//   test_mode               : select internal pattern (feature build only)
//   in_data/in_valid/in_ready : pixel stream; in_ready is state-derived
//   vsync, href, data[7:0]  : registered DVP bus
//   busy, frame_done, underflow : status (busy level, others 1-cycle pulses)
// All timing parameters must be >= 1.
//
// state  | meaning
// IDLE   | waiting for enable
// VSYNC  | vsync pulse, VSYNC_CYC cycles
// VBP    | vertical back porch, VBP_CYC cycles
// LINE   | active line, 2*WIDTH byte cycles
// HBLANK | gap between lines, HBLANK_CYC cycles
// VFP    | vertical front porch after last line, VFP_CYC cycles
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int VSYNC_CYC  = DEF_VSYNC_CYC,
  parameter int VBP_CYC    = DEF_VBP_CYC,
  parameter int HBLANK_CYC = DEF_HBLANK_CYC,
  parameter int VFP_CYC    = DEF_VFP_CYC
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        test_mode,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_HLAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] L_VLAST    = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] L_VSYNC_LD = CNT_W'(VSYNC_CYC - 1);
  localparam logic [CNT_W-1:0] L_VBP_LD   = CNT_W'(VBP_CYC - 1);
  localparam logic [CNT_W-1:0] L_HBL_LD   = CNT_W'(HBLANK_CYC - 1);
  localparam logic [CNT_W-1:0] L_VFP_LD   = CNT_W'(VFP_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] w_tmr_ld_val;
  logic             w_tmr_ld;
  logic             w_tc;
  logic             r_phase;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [7:0]       r_hi;
  logic             w_line_end;
  logic             w_last_line;
  logic             w_req;
  logic             w_pat_on;
  logic [15:0]      w_pat_pix;
  logic [15:0]      w_pix;

  assign w_tc        = (r_tmr == '0);
  assign w_last_line = (r_vcnt == L_VLAST);
  // Last byte cycle of a line: high-byte phase of the last pixel.
  assign w_line_end  = (r_state == LINE) && r_phase && (r_hcnt == L_HLAST);

  // The pixel fetch happens on the low-byte phase; outputs lag the state by
  // one register stage, so this lands one cycle before the low byte.
  assign w_req    = (r_state == LINE) && !r_phase && !w_pat_on;
  assign in_ready = w_req;
  assign busy     = (r_state != IDLE);

`ifdef DVP_TX_TEST_PATTERN_EN
  assign w_pat_on = test_mode;

  dvp_tx_pattern u_pattern (
    .i_hcnt  (r_hcnt[7:0]),
    .i_vcnt  (r_vcnt[7:0]),
    .o_pixel (w_pat_pix)
  );
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_pat_on           = 1'b0;
  assign w_pat_pix          = 16'h0000;
`endif

  always_comb begin
    w_pix = in_valid ? in_data : 16'h0000;
    if (w_pat_on) w_pix = w_pat_pix;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_ld     = 1'b0;
    w_tmr_ld_val = '0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt  = VSYNC;
          w_tmr_ld     = 1'b1;
          w_tmr_ld_val = L_VSYNC_LD;
        end
      end
      VSYNC: begin
        if (w_tc) begin
          w_state_nxt  = VBP;
          w_tmr_ld     = 1'b1;
          w_tmr_ld_val = L_VBP_LD;
        end
      end
      VBP: begin
        if (w_tc) w_state_nxt = LINE;
      end
      LINE: begin
        if (w_line_end) begin
          w_tmr_ld = 1'b1;
          if (w_last_line) begin
            w_state_nxt  = VFP;
            w_tmr_ld_val = L_VFP_LD;
          end else begin
            w_state_nxt  = HBLANK;
            w_tmr_ld_val = L_HBL_LD;
          end
        end
      end
      HBLANK: begin
        if (w_tc) w_state_nxt = LINE;
      end
      VFP: begin
        if (w_tc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_phase <= 1'b0;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tmr_ld) r_tmr <= w_tmr_ld_val;
      else if (!w_tc) r_tmr <= r_tmr - L_ONE;
      r_phase <= (r_state == LINE) ? ~r_phase : 1'b0;
      // Pixel wrap and line advance share the same edge.
      if ((r_state == LINE) && r_phase) begin
        if (r_hcnt == L_HLAST) begin
          r_hcnt <= '0;
          r_vcnt <= r_vcnt + L_ONE;
        end else begin
          r_hcnt <= r_hcnt + L_ONE;
        end
      end
      if (w_state_nxt == IDLE) begin
        r_hcnt <= '0;
        r_vcnt <= '0;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      r_hi       <= 8'h00;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      vsync      <= (r_state == VSYNC);
      href       <= (r_state == LINE);
      frame_done <= w_line_end && w_last_line;
      underflow  <= w_req && !in_valid;
      if (r_state == LINE) begin
        if (!r_phase) begin
          data <= w_pix[7:0];
          r_hi <= w_pix[15:8];
        end else begin
          data <= r_hi;
        end
      end else begin
        data <= 8'h00;
      end
    end
  end

endmodule
